// File: rtl/iter_alu_pkg.sv
// Shared opcode constants, FSM state encoding and legal-op decode for iter_alu.
// The multiply/divide codes are legal only when ITER_ALU_MULDIV_EN is defined.
package iter_alu_pkg;

  typedef logic [7:0] op_t;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Single-cycle operations
  localparam op_t OP_SUB    = 8'h00;
  localparam op_t OP_ADD    = 8'h01;
  localparam op_t OP_AND    = 8'h02;
  localparam op_t OP_OR     = 8'h03;
  localparam op_t OP_XOR    = 8'h04;
  localparam op_t OP_SRL    = 8'h05;
  localparam op_t OP_SLL    = 8'h06;
  localparam op_t OP_SRA    = 8'h07;
  localparam op_t OP_SLT    = 8'h08;
  localparam op_t OP_SLTU   = 8'h09;
  localparam op_t OP_ANDN   = 8'h10;
  localparam op_t OP_MAX    = 8'h11;
  localparam op_t OP_MAXU   = 8'h12;
  localparam op_t OP_MIN    = 8'h13;
  localparam op_t OP_MINU   = 8'h14;
  localparam op_t OP_ORN    = 8'h15;
  localparam op_t OP_SH1ADD = 8'h16;
  localparam op_t OP_SH2ADD = 8'h17;
  localparam op_t OP_SH3ADD = 8'h18;
  localparam op_t OP_XNOR   = 8'h19;

  // Iterative operations: bit 2 selects divide, bits [1:0] select the variant
  localparam op_t OP_MUL    = 8'h20;
  localparam op_t OP_MULH   = 8'h21;
  localparam op_t OP_MULHSU = 8'h22;
  localparam op_t OP_MULHU  = 8'h23;
  localparam op_t OP_DIV    = 8'h24;
  localparam op_t OP_DIVU   = 8'h25;
  localparam op_t OP_REM    = 8'h26;
  localparam op_t OP_REMU   = 8'h27;

  function automatic logic is_single(input op_t op);
    return (op <= OP_SLTU) || ((op >= OP_ANDN) && (op <= OP_XNOR));
  endfunction

  function automatic logic is_muldiv(input op_t op);
    return op[7:3] == 5'b00100;
  endfunction

  function automatic logic is_legal(input op_t op);
`ifdef ITER_ALU_MULDIV_EN
    return is_single(op) || is_muldiv(op);
`else
    return is_single(op);
`endif
  endfunction

endpackage

// File: rtl/iter_alu_muldiv.sv
// Radix-2 iterative multiplier / restoring divider, one bit per cycle.
// Operands are converted to magnitudes at start and the sign is fixed on the
// final cycle, so done and result appear in the WIDTH-th busy cycle.
module iter_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] hi, lo, b_q;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic             sa_en, sb_en, s1, s2;
  logic [WIDTH:0]   sum, trial;
  logic [2*WIDTH-1:0] prod;

  // Which operands are treated as signed for the requested variant
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sa_en = 1'b0;
    sb_en = 1'b0;
    if (!op[2]) begin
      sa_en = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
      sb_en = (op[1:0] == 2'b01);
    end else begin
      sa_en = !op[0];
      sb_en = !op[0];
    end
  end

  assign s1 = sa_en & num1[WIDTH-1];
  assign s2 = sb_en & num2[WIDTH-1];

  // One shift-add or restoring-subtract step from the current registers
  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    trial = {hi, lo[WIDTH-1]} - {1'b0, b_q};
    hi_nx = hi;
    lo_nx = lo;
    if (!op_q[2]) begin
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], lo[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      hi_nx = trial[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx = {hi[WIDTH-2:0], lo[WIDTH-1]};
      lo_nx = {lo[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and result selection on the last step
  always_comb begin
    prod   = {hi_nx, lo_nx};
    result = '0;
    if (!op_q[2]) begin
      if (neg_q) prod = -prod;
      result = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end else if (op_q[1]) begin
      result = neg_q ? -hi_nx : hi_nx;
    end else begin
      result = neg_q ? -lo_nx : lo_nx;
    end
  end

  assign done = busy && (cnt == CW'(WIDTH - 1));

  // Control state: busy flag and iteration counter
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      busy <= !done;
      cnt  <= done ? '0 : cnt + 1'b1;
    end
  end

  // Datapath registers load on start and step while busy
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; they are always loaded by start before use.
    if (start) begin
      op_q  <= op;
      neg_q <= (op[2] && op[1]) ? s1 : (s1 ^ s2);
      hi    <= '0;
      lo    <= s1 ? -num1 : num1;
      b_q   <= s2 ? -num2 : num2;
    end else if (busy) begin
      hi <= hi_nx;
      lo <= lo_nx;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU top: valid/ready request, IDLE -> BUSY/DONE -> IDLE FSM.
// Define ITER_ALU_MULDIV_EN to build the multiply/divide datapath (0x20-0x27);
// without it those codes are reported as illegal.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [OPW-1:0]   mode_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             error
);

  state_t           state;
  op_t              op;
  logic             op_hi_zero;
  logic [WIDTH-1:0] alu_res;

  assign op         = op_t'(mode_sel);
  assign op_hi_zero = (OPW <= 8) ? 1'b1 : ((mode_sel >> 8) == '0);
  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);

  // Single-cycle result for the operation being offered
  always_comb begin
    alu_res = '0;
    case (op)
      OP_SUB:    alu_res = num1 - num2;
      OP_ADD:    alu_res = num1 + num2;
      OP_AND:    alu_res = num1 & num2;
      OP_OR:     alu_res = num1 | num2;
      OP_XOR:    alu_res = num1 ^ num2;
      OP_SRL:    alu_res = num1 >> num2;
      OP_SLL:    alu_res = num1 << num2;
      OP_SRA:    alu_res = $signed(num1) >>> num2;
      OP_SLT:    alu_res = {{(WIDTH-1){1'b0}}, $signed(num1) < $signed(num2)};
      OP_SLTU:   alu_res = {{(WIDTH-1){1'b0}}, num1 < num2};
      OP_ANDN:   alu_res = num1 & ~num2;
      OP_MAX:    alu_res = ($signed(num1) > $signed(num2)) ? num1 : num2;
      OP_MAXU:   alu_res = (num1 > num2) ? num1 : num2;
      OP_MIN:    alu_res = ($signed(num1) < $signed(num2)) ? num1 : num2;
      OP_MINU:   alu_res = (num1 < num2) ? num1 : num2;
      OP_ORN:    alu_res = num1 | ~num2;
      OP_SH1ADD: alu_res = (num1 << 1) + num2;
      OP_SH2ADD: alu_res = (num1 << 2) + num2;
      OP_SH3ADD: alu_res = (num1 << 3) + num2;
      OP_XNOR:   alu_res = num1 ~^ num2;
      default:   alu_res = '0;
    endcase
  end

`ifdef ITER_ALU_MULDIV_EN
  logic             iter_op, div_zero, div_ovf, skip, start, md_done;
  logic [WIDTH-1:0] special_res, md_result;

  // Divide-by-zero and signed overflow are answered directly without iterating
  assign iter_op     = op_hi_zero && is_muldiv(op);
  assign div_zero    = (num2 == '0);
  assign div_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                       (num1 == {1'b1, {(WIDTH-1){1'b0}}}) && (num2 == '1);
  assign skip        = iter_op && op[2] && (div_zero || div_ovf);
  assign special_res = div_zero ? (op[1] ? num1 : '1) : (op[1] ? '0 : num1);
  assign start       = in_ready && in_valid && iter_op && !skip;

  iter_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op[2:0]),
    .num1   (num1),
    .num2   (num2),
    .done   (md_done),
    .result (md_result)
  );
`endif

  // Request/response FSM with registered ans and error
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ans   <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (op_hi_zero && is_single(op)) begin
              ans   <= alu_res;
              error <= 1'b0;
              state <= ST_DONE;
`ifdef ITER_ALU_MULDIV_EN
            end else if (skip) begin
              ans   <= special_res;
              error <= 1'b0;
              state <= ST_DONE;
            end else if (iter_op) begin
              state <= ST_BUSY;
`endif
            end else begin
              ans   <= '0;
              error <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
`ifdef ITER_ALU_MULDIV_EN
        ST_BUSY: begin
          if (md_done) begin
            ans   <= md_result;
            error <= 1'b0;
            state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
